demux_1to4_reg: RTL and testbench

Registered 1-to-4 demultiplexer with a valid/ready handshake on each side. It is the fan-out counterpart of the CPU's 4-to-1 select muxes. One input stream enters and is steered by `select_i`, or copied to all four ports when `bcast_i` is set. Each destination has its own one-entry holding register. It sits between a single producer, such as a write-back or forwarding source, and four independent consumers that may stall separately.

---
 rtl/demux_1to4_reg_if.sv | 24 ++
 rtl/demux_1to4_reg.sv | 41 ++++
 tb/tb_demux_1to4_reg.sv | 106 ++++++++++
 3 files changed

// File: rtl/demux_1to4_reg_if.sv
// demux_1to4_reg_if: producer-side stream plus four consumer-side ports of the registered 1-to-4 demux
//   data_i/select_i/bcast_i/valid_i/ready_o : input stream handshake
//   data00_o..data11_o/valid_o/ready_i      : per-port holding registers and handshakes
interface demux_1to4_reg_if #(parameter int size = 32);
    logic [size-1:0] data_i;
    logic [1:0]      select_i;
    logic            bcast_i;
    logic            valid_i;
    logic            ready_o;
    logic [size-1:0] data00_o;
    logic [size-1:0] data01_o;
    logic [size-1:0] data10_o;
    logic [size-1:0] data11_o;
    logic [3:0]      valid_o;
    logic [3:0]      ready_i;
    modport slave (
        input  data_i, select_i, bcast_i, valid_i, ready_i,
        output ready_o, data00_o, data01_o, data10_o, data11_o, valid_o
    );
    modport master (
        output data_i, select_i, bcast_i, valid_i, ready_i,
        input  ready_o, data00_o, data01_o, data10_o, data11_o, valid_o
    );
endinterface

// File: rtl/demux_1to4_reg.sv
// demux_1to4_reg: registered 1-to-4 demux with per-port one-entry slots, unicast or all-or-nothing broadcast
//   clk_i : clock, rising edge
//   rst_i : asynchronous reset, active-low
//   bus   : slave side of demux_1to4_reg_if (input stream and four output ports)
module demux_1to4_reg #(parameter int size = 32) (
    input logic             clk_i,
    input logic             rst_i,
    demux_1to4_reg_if.slave bus
);
    logic [size-1:0] r_data [4];
    logic [3:0]      r_valid;
    logic [3:0]      w_can;
    logic [3:0]      w_load;
    logic            w_ready;
    // a slot can take new data when empty or draining on this same edge
    assign w_can   = ~r_valid | bus.ready_i;
    assign w_ready = rst_i & (bus.bcast_i ? &w_can : w_can[bus.select_i]);
    assign w_load  = {4{bus.valid_i & w_ready}} & (bus.bcast_i ? 4'b1111 : 4'b0001 << bus.select_i);
    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_slot
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    r_data[k]  <= '0;
                    r_valid[k] <= 1'b0;
                end else begin
                    if (w_load[k])
                        r_data[k] <= bus.data_i;
                    // load wins over drain, so back-to-back transfers keep valid high
                    r_valid[k] <= w_load[k] | (r_valid[k] & ~bus.ready_i[k]);
                end
            end
        end
    endgenerate
    assign bus.ready_o  = w_ready;
    assign bus.valid_o  = r_valid;
    assign bus.data00_o = r_data[0];
    assign bus.data01_o = r_data[1];
    assign bus.data10_o = r_data[2];
    assign bus.data11_o = r_data[3];
endmodule

// File: tb/tb_demux_1to4_reg.sv
// tb_demux_1to4_reg: scoreboard bench for demux_1to4_reg with directed and random stimulus
module tb_demux_1to4_reg;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    demux_1to4_reg_if #(.size(32)) bus ();
    demux_1to4_reg #(.size(32)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
    always #5 clk_i = ~clk_i;
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] q [4][$];
    logic [31:0] lastw [4];
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask
    function automatic logic [31:0] port_data(input int k);
        return k == 0 ? bus.data00_o : k == 1 ? bus.data01_o : k == 2 ? bus.data10_o : bus.data11_o;
    endfunction
    function automatic logic model_ready();
        logic [3:0] can;
        for (int k = 0; k < 4; k++) can[k] = q[k].size() == 0 || bus.ready_i[k];
        return rst_i && (bus.bcast_i ? &can : can[bus.select_i]);
    endfunction
    // monitor: compare every port against the scoreboard, then retire items the consumer takes
    always @(negedge clk_i) begin
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("valid%0d", k), {31'b0, bus.valid_o[k]}, {31'b0, q[k].size() != 0});
            chk($sformatf("data%0d", k), port_data(k), q[k].size() != 0 ? q[k][0] : lastw[k]);
        end
        chk("ready_o", {31'b0, bus.ready_o}, {31'b0, model_ready()});
        for (int k = 0; k < 4; k++)
            if (rst_i && q[k].size() != 0 && bus.ready_i[k]) void'(q[k].pop_front());
    end
    // drive one transfer, starting just after a rising edge; returns just after the accepting edge
    task automatic send(input logic [31:0] d, input logic [1:0] s, input logic b,
                        input logic [3:0] rdy, input int raise_at, input logic rnd);
        int cyc = 0;
        logic acc = 1'b0;
        bus.data_i = d; bus.select_i = s; bus.bcast_i = b; bus.valid_i = 1'b1; bus.ready_i = rdy;
        while (!acc && cyc < 200) begin
            @(negedge clk_i); #2;
            if (bus.ready_o) begin
                acc = 1'b1;
                for (int k = 0; k < 4; k++)
                    if (b || s == k[1:0]) begin
                        q[k].push_back(d);
                        lastw[k] = d;
                    end
            end
            @(posedge clk_i); #1;
            cyc++;
            if (cyc == raise_at) bus.ready_i = 4'b1111;
            if (rnd) bus.ready_i = 4'($urandom);
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        bus.valid_i = 1'b0;
    endtask
    task automatic idle(input int n, input logic [3:0] rdy);
        bus.valid_i = 1'b0; bus.ready_i = rdy;
        repeat (n) begin
            @(posedge clk_i); #1;
        end
    endtask
    task automatic reset_now();
        #2 rst_i = 1'b0;
        #1;
        chk("rst_valid", {28'b0, bus.valid_o}, 32'd0);
        for (int k = 0; k < 4; k++) chk($sformatf("rst_data%0d", k), port_data(k), 32'd0);
        chk("rst_ready", {31'b0, bus.ready_o}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            q[k].delete();
            lastw[k] = '0;
        end
        @(negedge clk_i); #3 rst_i = 1'b1;
        @(posedge clk_i); #1;
    endtask
    initial begin
        for (int k = 0; k < 4; k++) lastw[k] = '0;
        bus.data_i = '0; bus.select_i = '0; bus.bcast_i = 1'b0; bus.valid_i = 1'b0; bus.ready_i = '0;
        repeat (2) @(posedge clk_i);
        #1 reset_now();
        for (int i = 0; i < 4; i++) send(32'h11 * (i + 1), 2'(i), 1'b0, 4'b1111, -1, 1'b0);
        idle(2, 4'b1111);
        send(32'hA5, 2'b00, 1'b0, 4'b1110, -1, 1'b0);
        send(32'h5A, 2'b01, 1'b0, 4'b1110, -1, 1'b0);
        send(32'hC3, 2'b00, 1'b0, 4'b1110, 2, 1'b0);
        idle(2, 4'b1111);
        send(32'h1, 2'b11, 1'b0, 4'b0111, -1, 1'b0);
        send(32'h2, 2'b11, 1'b0, 4'b1111, -1, 1'b0);
        idle(1, 4'b0111);
        send(32'hDEAD, 2'b00, 1'b1, 4'b0111, 3, 1'b0);
        idle(2, 4'b0000);
        idle(2, 4'b1111);
        send(32'h77, 2'b00, 1'b0, 4'b1010, -1, 1'b0);
        send(32'h99, 2'b10, 1'b0, 4'b1010, -1, 1'b0);
        reset_now();
        for (int i = 0; i < 300; i++)
            send($urandom, 2'($urandom), $urandom_range(0, 7) == 0, 4'($urandom), -1, 1'b1);
        idle(3, 4'b1111);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
